// File: rtl/serial_word_collector.sv
// serial_word_collector
// Collects a framed serial bit stream MSB-first into WIDTH-bit words and
// presents each completed word, with its even parity, through a single-entry
// valid/ready output register. A word completed while the register is still
// occupied (and not being accepted on that edge) is dropped and recorded in a
// sticky overflow flag.

module serial_word_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_par,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clear_ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Even-parity bit of a completed word.
  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-2:0] shreg_r;
  logic [WIDTH-2:0] shreg_s;
  logic             busy_s;

  logic             capture_s;
  logic             complete_s;
  logic [WIDTH-1:0] full_word_s;
  logic             load_s;
  logic             drop_s;
  logic             valid_s;
  logic             ovf_s;

  // A bit is taken only inside a frame, and an abort (frame_start) wins over it.
  assign capture_s   = (state_r == COLLECT) && bit_en && !frame_start;
  assign complete_s  = capture_s && (cnt_r == CNT_LAST);
  assign full_word_s = {shreg_r, bit_in};
  assign load_s      = complete_s && (!word_valid || word_ready);
  assign drop_s      = complete_s && word_valid && !word_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: frame_start always (re)enters COLLECT, the last bit leaves it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          state_s = COLLECT;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          state_s = COLLECT;
        end else if (complete_s) begin
          state_s = IDLE;
        end else begin
          state_s = COLLECT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM output logic: busy mirrors the state being entered so it is registered.
  always_comb begin
    busy_s = 1'b0;
    if (state_s == COLLECT) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Bit counter and shift register next values: clear on start/abort/completion, shift on capture.
  always_comb begin
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    if (frame_start) begin
      cnt_s   = {CW{1'b0}};
      shreg_s = {(WIDTH-1){1'b0}};
    end else if (complete_s) begin
      cnt_s   = {CW{1'b0}};
      shreg_s = {(WIDTH-1){1'b0}};
    end else if (capture_s) begin
      cnt_s   = cnt_r + CW'(1'b1);
      shreg_s = full_word_s[WIDTH-2:0];
    end else begin
      cnt_s   = cnt_r;
      shreg_s = shreg_r;
    end
  end

  // Output register occupancy and sticky overflow; a drop beats a simultaneous clear.
  always_comb begin
    valid_s = word_valid;
    ovf_s   = overflow;
    if (load_s) begin
      valid_s = 1'b1;
    end else if (word_valid && word_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = word_valid;
    end
    if (drop_s) begin
      ovf_s = 1'b1;
    end else if (clear_ovf) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = overflow;
    end
  end

  // Collector datapath registers and busy flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r   <= {CW{1'b0}};
      shreg_r <= {(WIDTH-1){1'b0}};
      busy    <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      busy    <= busy_s;
    end
  end

  // Output word register: loaded only when a completed word is accepted into it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_out   <= {WIDTH{1'b0}};
      word_par   <= 1'b0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load_s) begin
        word_out <= full_word_s;
        word_par <= parity_of(full_word_s);
      end else begin
        word_out <= word_out;
        word_par <= word_par;
      end
      word_valid <= valid_s;
      overflow   <= ovf_s;
    end
  end

endmodule
